cache_set: RTL and testbench
============================

CACHE_SET -- requirements
Module: cache_set

Interface
REQ-001 SHALL have parameter TAG_WIDTH, default 20, tag bits per way.
REQ-002 SHALL have parameter OFFSET_WIDTH, default 4, word-offset bits; line = 2**OFFSET_WIDTH words.
REQ-003 SHALL have parameter DATA_WIDTH, default 32, word bits, multiple of 8.
REQ-004 SHALL have parameter WAY_NUM, default 4, ways per set, power of 2, >= 2; WB = log2(WAY_NUM).
REQ-005 SHALL have port clk  in  1  single clock, all state on rising edge.
REQ-006 SHALL have port rst  in  1  reset, asynchronous, active-low.
REQ-007 SHALL have ports req_valid in 1, req_ready out 1, req_write in 1, req_tag in TAG_WIDTH, req_offset in OFFSET_WIDTH, req_byte_en in DATA_WIDTH/8, req_wdata in DATA_WIDTH: lookup request.
REQ-008 SHALL have ports rsp_valid out 1, rsp_hit out 1, rsp_way out WB, rsp_rdata out DATA_WIDTH: lookup response.
REQ-009 SHALL have ports miss_valid out 1, miss_dirty out 1, miss_tag out TAG_WIDTH, miss_way out WB: victim to write back or refill.
REQ-010 SHALL have ports refill_valid in 1, refill_offset in OFFSET_WIDTH, refill_data in DATA_WIDTH, refill_last in 1: line fill beats.
REQ-011 SHALL have port flush  in  1  invalidate all ways.

Function
REQ-012 SHALL hold per way: valid, dirty, tag, 2**OFFSET_WIDTH data words, WB-bit LRU age.
REQ-013 SHALL implement FSM IDLE / MISS; req_ready = (state==IDLE) && !flush.
REQ-014 SHALL accept a request when req_valid && req_ready; rsp_valid pulses exactly one cycle later, for exactly one cycle.
REQ-015 SHALL define hit as any way with valid==1 and tag==req_tag; rsp_way = hit way, rsp_hit=1.
REQ-016 Read hit SHALL return the stored word at req_offset on rsp_rdata; write hit SHALL merge req_wdata bytes where req_byte_en=1, set dirty=1, return rsp_rdata=0.
REQ-017 A read accepted the cycle after a write hit to the same way/offset SHALL return the merged data.
REQ-018 Any hit SHALL touch the way: ages below its age increment by 1, its age becomes 0.
REQ-019 Miss SHALL give rsp_hit=0, rsp_rdata=0, rsp_way=victim, enter MISS on the response cycle, latch req_tag.
REQ-020 Victim SHALL be the lowest-index invalid way, else the way with age WAY_NUM-1.
REQ-021 In MISS, miss_valid=1 with miss_way=victim, miss_dirty=victim dirty, miss_tag=victim old tag, all stable until exit; miss_valid=0 in IDLE.
REQ-022 In MISS, each refill_valid beat SHALL write refill_data (all bytes) to victim word refill_offset.
REQ-023 Beat with refill_last=1 SHALL set victim tag=latched tag, valid=1, dirty=0, touch victim (REQ-018), return to IDLE next cycle.
REQ-024 refill_valid in IDLE SHALL be ignored; write miss SHALL NOT store req_wdata (requester retries after refill).
REQ-025 flush in IDLE SHALL clear all valid and dirty bits in one cycle, ages unchanged; flush in MISS SHALL be ignored.
REQ-026 Ages SHALL always form a permutation of 0..WAY_NUM-1.

Reset
REQ-027 rst=0 SHALL immediately force state=IDLE, all valid=0, dirty=0, tag=0, age[i]=i, rsp_valid=0, rsp_hit=0, rsp_way=0, rsp_rdata=0, miss_valid=0, miss_dirty=0, miss_tag=0, miss_way=0; data words not reset.
REQ-028 Reset asserted during MISS SHALL abandon the refill; the partially filled way remains invalid.
REQ-029 req_ready SHALL be 1 in the first cycle after rst deasserts (flush=0).

Verification
REQ-030 After reset, read tag 0x12345 offset 3 -> next cycle rsp_valid=1, rsp_hit=0, rsp_way=0, miss_valid=1, miss_dirty=0, req_ready=0.
REQ-031 Refill 16 beats data=0xA0+offset, last on beat 15 -> IDLE; read offset 5 -> rsp_hit=1, rsp_way=0, rsp_rdata=0xA5.
REQ-032 Write byte_en=4'b0011 wdata=0xFFFFBEEF to offset 5, read offset 5 next cycle -> rsp_rdata=0x0000BEEF.
REQ-033 Fill ways 0..3 with tags T0..T3, hit T0, then miss T4 -> miss_way=1, miss_tag=T1, miss_dirty=0.
REQ-034 Dirty way 0, miss selects it -> miss_dirty=1; assert rst mid-refill -> all outputs 0, next lookup of new tag misses.
REQ-035 flush with req_valid same cycle -> req_ready=0, request not accepted; following lookups of all prior tags -> rsp_hit=0.

Source files
------------

// File: rtl/cache_set_if.sv
// Bus bundle for one cache set: lookup request/response, victim report and refill beats.
// Handshake: a request transfers on a rising edge where req_valid && req_ready are both 1;
// the requester holds its fields stable while req_valid is 1. rsp_valid, refill_valid and
// miss_valid have no ready: the receiver must take them in the cycle they are high.
interface cache_set_if #(
    parameter int TAG_WIDTH    = 20,
    parameter int OFFSET_WIDTH = 4,
    parameter int DATA_WIDTH   = 32,
    parameter int WAY_NUM      = 4
);
    localparam int WB = (WAY_NUM > 1) ? $clog2(WAY_NUM) : 1;

    logic                    req_valid;
    logic                    req_ready;
    logic                    req_write;
    logic [TAG_WIDTH-1:0]    req_tag;
    logic [OFFSET_WIDTH-1:0] req_offset;
    logic [DATA_WIDTH/8-1:0] req_byte_en;
    logic [DATA_WIDTH-1:0]   req_wdata;

    logic                    rsp_valid;
    logic                    rsp_hit;
    logic [WB-1:0]           rsp_way;
    logic [DATA_WIDTH-1:0]   rsp_rdata;

    logic                    miss_valid;
    logic                    miss_dirty;
    logic [TAG_WIDTH-1:0]    miss_tag;
    logic [WB-1:0]           miss_way;

    logic                    refill_valid;
    logic [OFFSET_WIDTH-1:0] refill_offset;
    logic [DATA_WIDTH-1:0]   refill_data;
    logic                    refill_last;

    logic                    flush;

    modport master (
        output req_valid, req_write, req_tag, req_offset, req_byte_en, req_wdata,
        output refill_valid, refill_offset, refill_data, refill_last, flush,
        input  req_ready, rsp_valid, rsp_hit, rsp_way, rsp_rdata,
        input  miss_valid, miss_dirty, miss_tag, miss_way
    );

    modport slave (
        input  req_valid, req_write, req_tag, req_offset, req_byte_en, req_wdata,
        input  refill_valid, refill_offset, refill_data, refill_last, flush,
        output req_ready, rsp_valid, rsp_hit, rsp_way, rsp_rdata,
        output miss_valid, miss_dirty, miss_tag, miss_way
    );
endinterface

// File: rtl/cache_set.sv
// One set of a set-associative cache: tag lookup with byte-merge writes, age-based LRU,
// victim selection on miss and line refill from the next level.
module cache_set #(
    parameter int TAG_WIDTH    = 20,
    parameter int OFFSET_WIDTH = 4,
    parameter int DATA_WIDTH   = 32,
    parameter int WAY_NUM      = 4
) (
    input  logic       clk,
    input  logic       rst,
    cache_set_if.slave bus,
    output logic       state_debug
);
    localparam int WB    = (WAY_NUM > 1) ? $clog2(WAY_NUM) : 1;
    localparam int LINE  = 2 ** OFFSET_WIDTH;
    localparam int BYTES = DATA_WIDTH / 8;

    typedef enum logic {IDLE = 1'b0, MISS = 1'b1} state_t;
    state_t state_q, state_d;

    logic [WAY_NUM-1:0]    valid_q;
    logic [WAY_NUM-1:0]    dirty_q;
    logic [TAG_WIDTH-1:0]  tag_q  [WAY_NUM];
    logic [WB-1:0]         age_q  [WAY_NUM];
    logic [DATA_WIDTH-1:0] data_q [WAY_NUM][LINE];

    logic [TAG_WIDTH-1:0]  fill_tag_q;
    logic [WB-1:0]         miss_way_q;
    logic                  miss_dirty_q;
    logic [TAG_WIDTH-1:0]  miss_tag_q;
    logic                  rsp_valid_q;
    logic                  rsp_hit_q;
    logic [WB-1:0]         rsp_way_q;
    logic [DATA_WIDTH-1:0] rsp_rdata_q;

    logic          hit;
    logic [WB-1:0] hit_way;
    logic [WB-1:0] victim;
    logic          ready;
    logic          accept;
    logic          refill_beat;
    logic          fill_done;
    logic          flush_now;
    logic          touch_en;
    logic [WB-1:0] touch_way;

    // Tag compare (lowest index wins) and victim choice: lowest invalid way, else the oldest.
    always_comb begin
        hit     = 1'b0;
        hit_way = '0;
        victim  = '0;
        for (int i = WAY_NUM - 1; i >= 0; i--) begin
            if (valid_q[i] && tag_q[i] == bus.req_tag) begin
                hit     = 1'b1;
                hit_way = WB'(i);
            end
        end
        for (int i = 0; i < WAY_NUM; i++) begin
            if (age_q[i] == WB'(WAY_NUM - 1)) victim = WB'(i);
        end
        for (int i = WAY_NUM - 1; i >= 0; i--) begin
            if (!valid_q[i]) victim = WB'(i);
        end
    end

    // Next-state and handshake decode; a miss parks the set until the last refill beat.
    always_comb begin
        state_d     = state_q;
        ready       = 1'b0;
        accept      = 1'b0;
        refill_beat = 1'b0;
        fill_done   = 1'b0;
        case (state_q)
            IDLE: begin
                ready  = !bus.flush;
                accept = bus.req_valid && ready;
                if (accept && !hit) state_d = MISS;
            end
            MISS: begin
                refill_beat = bus.refill_valid;
                fill_done   = bus.refill_valid && bus.refill_last;
                if (fill_done) state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    assign flush_now = (state_q == IDLE) && bus.flush;
    assign touch_en  = (accept && hit) || fill_done;
    assign touch_way = fill_done ? miss_way_q : hit_way;

    // FSM state register.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) state_q <= IDLE;
        else      state_q <= state_d;
    end

    // LRU ages: the touched way becomes youngest, every way younger than it ages by one.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int i = 0; i < WAY_NUM; i++) age_q[i] <= WB'(i);
        end else if (touch_en) begin
            for (int i = 0; i < WAY_NUM; i++) begin
                if (WB'(i) == touch_way)              age_q[i] <= '0;
                else if (age_q[i] < age_q[touch_way]) age_q[i] <= age_q[i] + 1'b1;
            end
        end
    end

    // Line metadata: flush drops valid/dirty, write hits dirty the line, last beat installs it.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            valid_q <= '0;
            dirty_q <= '0;
            for (int i = 0; i < WAY_NUM; i++) tag_q[i] <= '0;
        end else if (flush_now) begin
            valid_q <= '0;
            dirty_q <= '0;
        end else if (accept && hit && bus.req_write) begin
            dirty_q[hit_way] <= 1'b1;
        end else if (fill_done) begin
            tag_q[miss_way_q]   <= fill_tag_q;
            valid_q[miss_way_q] <= 1'b1;
            dirty_q[miss_way_q] <= 1'b0;
        end
    end

    // Data words are not reset; a way only becomes readable after a complete install.
    always_ff @(posedge clk) begin
        if (accept && hit && bus.req_write) begin
            for (int b = 0; b < BYTES; b++) begin
                if (bus.req_byte_en[b])
                    data_q[hit_way][bus.req_offset][b*8 +: 8] <= bus.req_wdata[b*8 +: 8];
            end
        end else if (refill_beat) begin
            data_q[miss_way_q][bus.refill_offset] <= bus.refill_data;
        end
    end

    // Response pulse plus victim capture; the victim fields stay frozen for the whole miss.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            rsp_valid_q  <= 1'b0;
            rsp_hit_q    <= 1'b0;
            rsp_way_q    <= '0;
            rsp_rdata_q  <= '0;
            miss_way_q   <= '0;
            miss_dirty_q <= 1'b0;
            miss_tag_q   <= '0;
            fill_tag_q   <= '0;
        end else begin
            rsp_valid_q <= accept;
            if (accept) begin
                rsp_hit_q   <= hit;
                rsp_way_q   <= hit ? hit_way : victim;
                rsp_rdata_q <= (hit && !bus.req_write) ? data_q[hit_way][bus.req_offset] : '0;
            end
            if (accept && !hit) begin
                miss_way_q   <= victim;
                miss_dirty_q <= dirty_q[victim];
                miss_tag_q   <= tag_q[victim];
                fill_tag_q   <= bus.req_tag;
            end
        end
    end

    assign bus.req_ready  = ready;
    assign bus.rsp_valid  = rsp_valid_q;
    assign bus.rsp_hit    = rsp_hit_q;
    assign bus.rsp_way    = rsp_way_q;
    assign bus.rsp_rdata  = rsp_rdata_q;
    assign bus.miss_valid = (state_q == MISS);
    assign bus.miss_dirty = miss_dirty_q;
    assign bus.miss_tag   = miss_tag_q;
    assign bus.miss_way   = miss_way_q;
    assign state_debug    = state_q;
endmodule

// File: tb/tb_cache_set.sv
// Bench for cache_set: directed scenarios with literal expectations, then random traffic,
// all compared against an LRU-list model of the set.
module tb_cache_set;
    localparam int TW   = 20;
    localparam int OW   = 4;
    localparam int DW   = 32;
    localparam int WN   = 4;
    localparam int WB   = 2;
    localparam int LINE = 16;
    localparam int BY   = DW / 8;

    logic clk = 1'b0;
    logic rst;
    logic state_debug;
    int   errors = 0;
    int   checks = 0;

    cache_set_if #(.TAG_WIDTH(TW), .OFFSET_WIDTH(OW), .DATA_WIDTH(DW), .WAY_NUM(WN)) bus ();

    cache_set #(.TAG_WIDTH(TW), .OFFSET_WIDTH(OW), .DATA_WIDTH(DW), .WAY_NUM(WN)) dut (
        .clk(clk), .rst(rst), .bus(bus), .state_debug(state_debug)
    );

    // ---------------- clock / reset ----------------
    always #5 clk = ~clk;

    // ---------------- reference model ----------------
    bit                  m_valid [WN];
    bit                  m_dirty [WN];
    logic [TW-1:0]       m_tag   [WN];
    logic [DW-1:0]       m_data  [WN][LINE];
    int                  order[$];          // most recently used way first
    bit                  m_miss;
    int                  m_victim;
    logic [TW-1:0]       m_fill_tag;
    bit                  e_rsp_valid;
    bit                  e_miss_dirty;
    logic [TW-1:0]       e_miss_tag;
    logic [1+WB+DW-1:0]  exp_q[$];          // {hit, way, rdata} per accepted request

    task automatic model_reset();
        for (int i = 0; i < WN; i++) begin
            m_valid[i] = 1'b0;
            m_dirty[i] = 1'b0;
            m_tag[i]   = '0;
        end
        order.delete();
        for (int i = 0; i < WN; i++) order.push_back(i);
        m_miss       = 1'b0;
        m_victim     = 0;
        m_fill_tag   = '0;
        e_rsp_valid  = 1'b0;
        e_miss_dirty = 1'b0;
        e_miss_tag   = '0;
        exp_q.delete();
    endtask

    function automatic int lookup(input logic [TW-1:0] t);
        for (int i = 0; i < WN; i++) if (m_valid[i] && m_tag[i] == t) return i;
        return -1;
    endfunction

    function automatic int pick_victim();
        for (int i = 0; i < WN; i++) if (!m_valid[i]) return i;
        return order[order.size()-1];
    endfunction

    task automatic touch(input int w);
        for (int i = 0; i < order.size(); i++) begin
            if (order[i] == w) begin
                order.delete(i);
                break;
            end
        end
        order.push_front(w);
    endtask

    task automatic model_step();
        int w;
        int v;
        e_rsp_valid = 1'b0;
        if (!m_miss) begin
            if (bus.flush) begin
                for (int i = 0; i < WN; i++) begin
                    m_valid[i] = 1'b0;
                    m_dirty[i] = 1'b0;
                end
            end else if (bus.req_valid) begin
                e_rsp_valid = 1'b1;
                w = lookup(bus.req_tag);
                if (w >= 0) begin
                    if (bus.req_write) begin
                        for (int b = 0; b < BY; b++)
                            if (bus.req_byte_en[b])
                                m_data[w][bus.req_offset][8*b +: 8] = bus.req_wdata[8*b +: 8];
                        m_dirty[w] = 1'b1;
                        exp_q.push_back({1'b1, WB'(w), {DW{1'b0}}});
                    end else begin
                        exp_q.push_back({1'b1, WB'(w), m_data[w][bus.req_offset]});
                    end
                    touch(w);
                end else begin
                    v            = pick_victim();
                    m_miss       = 1'b1;
                    m_victim     = v;
                    e_miss_dirty = m_dirty[v];
                    e_miss_tag   = m_tag[v];
                    m_fill_tag   = bus.req_tag;
                    exp_q.push_back({1'b0, WB'(v), {DW{1'b0}}});
                end
            end
        end else if (bus.refill_valid) begin
            m_data[m_victim][bus.refill_offset] = bus.refill_data;
            if (bus.refill_last) begin
                m_tag[m_victim]   = m_fill_tag;
                m_valid[m_victim] = 1'b1;
                m_dirty[m_victim] = 1'b0;
                touch(m_victim);
                m_miss = 1'b0;
            end
        end
    endtask

    // Model follows the same edges as the design, including the asynchronous reset.
    always @(negedge rst) model_reset();
    always @(posedge clk) begin
        if (!rst) model_reset();
        else      model_step();
    end

    // ---------------- scoreboard ----------------
    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    always @(negedge clk) begin
        logic [1+WB+DW-1:0] e;
        check("req_ready", bus.req_ready, !m_miss && !bus.flush);
        check("state", state_debug, m_miss);
        check("rsp_valid", bus.rsp_valid, e_rsp_valid);
        if (e_rsp_valid && exp_q.size() > 0) begin
            e = exp_q.pop_front();
            check("rsp_hit", bus.rsp_hit, e[WB+DW]);
            check("rsp_way", bus.rsp_way, e[WB+DW-1:DW]);
            check("rsp_rdata", bus.rsp_rdata, e[DW-1:0]);
        end
        check("miss_valid", bus.miss_valid, m_miss);
        if (m_miss) begin
            check("miss_way", bus.miss_way, m_victim);
            check("miss_dirty", bus.miss_dirty, e_miss_dirty);
            check("miss_tag", bus.miss_tag, e_miss_tag);
        end
        if (rst === 1'b0) begin
            check("rst_rsp_hit", bus.rsp_hit, 0);
            check("rst_rsp_way", bus.rsp_way, 0);
            check("rst_rsp_rdata", bus.rsp_rdata, 0);
            check("rst_miss_dirty", bus.miss_dirty, 0);
            check("rst_miss_tag", bus.miss_tag, 0);
            check("rst_miss_way", bus.miss_way, 0);
        end
    end

    // ---------------- driver tasks ----------------
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        bus.req_valid     = 1'b0;
        bus.req_write     = 1'b0;
        bus.req_tag       = '0;
        bus.req_offset    = '0;
        bus.req_byte_en   = '0;
        bus.req_wdata     = '0;
        bus.refill_valid  = 1'b0;
        bus.refill_offset = '0;
        bus.refill_data   = '0;
        bus.refill_last   = 1'b0;
        bus.flush         = 1'b0;
    endtask

    task automatic issue(input bit wr, input logic [TW-1:0] tag, input logic [OW-1:0] off,
                         input logic [BY-1:0] be, input logic [DW-1:0] wd);
        bus.req_valid   = 1'b1;
        bus.req_write   = wr;
        bus.req_tag     = tag;
        bus.req_offset  = off;
        bus.req_byte_en = be;
        bus.req_wdata   = wd;
        step();
        bus.req_valid   = 1'b0;
    endtask

    task automatic refill_line(input logic [DW-1:0] base);
        for (int off = 0; off < LINE; off++) begin
            if ($urandom_range(0, 3) == 0) step();
            bus.refill_valid  = 1'b1;
            bus.refill_offset = OW'(off);
            bus.refill_data   = base + DW'(off);
            bus.refill_last   = (off == LINE - 1);
            step();
        end
        bus.refill_valid = 1'b0;
        bus.refill_last  = 1'b0;
    endtask

    task automatic miss_fill(input logic [TW-1:0] tag, input logic [DW-1:0] base);
        issue(1'b0, tag, '0, '0, '0);
        refill_line(base);
    endtask

    // ---------------- stimulus ----------------
    localparam logic [TW-1:0] T0 = 20'h12345;
    localparam logic [TW-1:0] T1 = 20'h00111;
    localparam logic [TW-1:0] T2 = 20'h00222;
    localparam logic [TW-1:0] T3 = 20'h00333;
    localparam logic [TW-1:0] T4 = 20'h00444;
    localparam logic [TW-1:0] T5 = 20'h00555;
    localparam logic [TW-1:0] T6 = 20'h00666;

    initial begin
        logic [TW-1:0] pool [6];
        int beat;
        pool[0] = T0; pool[1] = T1; pool[2] = T2;
        pool[3] = T3; pool[4] = T4; pool[5] = 20'hFFFFF;

        idle();
        rst = 1'b0;
        model_reset();
        repeat (3) @(posedge clk);
        #1 rst = 1'b1;
        @(negedge clk);
        check("ready_after_reset", bus.req_ready, 1);
        step();

        // first lookup after reset misses into way 0
        issue(1'b0, T0, 4'd3, '0, '0);
        @(negedge clk);
        check("d1_rsp_valid", bus.rsp_valid, 1);
        check("d1_rsp_hit", bus.rsp_hit, 0);
        check("d1_rsp_way", bus.rsp_way, 0);
        check("d1_miss_valid", bus.miss_valid, 1);
        check("d1_miss_dirty", bus.miss_dirty, 0);
        check("d1_req_ready", bus.req_ready, 0);
        check("d1_model_victim", m_victim, 0);
        step();

        // refill A0+offset and read a word back
        refill_line(32'hA0);
        issue(1'b0, T0, 4'd5, '0, '0);
        @(negedge clk);
        check("d2_rsp_hit", bus.rsp_hit, 1);
        check("d2_rsp_way", bus.rsp_way, 0);
        check("d2_rsp_rdata", bus.rsp_rdata, 32'hA5);
        step();

        // partial-byte write followed immediately by a read of the same word
        issue(1'b1, T0, 4'd5, 4'b0011, 32'hFFFFBEEF);
        issue(1'b0, T0, 4'd5, '0, '0);
        @(negedge clk);
        check("d3_rsp_rdata", bus.rsp_rdata, 32'h0000BEEF);
        check("d3_model_rdata", m_data[0][5], 32'h0000BEEF);
        step();

        // fill remaining ways, touch T0, then a miss must evict way 1
        miss_fill(T1, 32'h100);
        miss_fill(T2, 32'h200);
        miss_fill(T3, 32'h300);
        issue(1'b0, T0, 4'd1, '0, '0);
        issue(1'b0, T4, 4'd2, '0, '0);
        @(negedge clk);
        check("d4_rsp_hit", bus.rsp_hit, 0);
        check("d4_miss_valid", bus.miss_valid, 1);
        check("d4_miss_way", bus.miss_way, 1);
        check("d4_miss_tag", bus.miss_tag, T1);
        check("d4_miss_dirty", bus.miss_dirty, 0);
        step();
        refill_line(32'h400);

        // age way 0 (dirty) to oldest, miss onto it, then reset in the middle of the refill
        issue(1'b0, T2, 4'd0, '0, '0);
        issue(1'b0, T3, 4'd0, '0, '0);
        issue(1'b0, T4, 4'd0, '0, '0);
        issue(1'b0, T5, 4'd0, '0, '0);
        @(negedge clk);
        check("d5_miss_way", bus.miss_way, 0);
        check("d5_miss_dirty", bus.miss_dirty, 1);
        check("d5_miss_tag", bus.miss_tag, T0);
        step();
        for (int off = 0; off < 5; off++) begin
            bus.refill_valid  = 1'b1;
            bus.refill_offset = OW'(off);
            bus.refill_data   = $urandom;
            step();
        end
        bus.refill_valid = 1'b0;
        rst = 1'b0;
        @(negedge clk);
        check("d6_rsp_valid", bus.rsp_valid, 0);
        check("d6_rsp_rdata", bus.rsp_rdata, 0);
        check("d6_miss_valid", bus.miss_valid, 0);
        check("d6_miss_tag", bus.miss_tag, 0);
        check("d6_miss_way", bus.miss_way, 0);
        step();
        rst = 1'b1;
        @(negedge clk);
        check("d6_ready", bus.req_ready, 1);
        step();
        issue(1'b0, T5, 4'd0, '0, '0);
        @(negedge clk);
        check("d7_rsp_hit", bus.rsp_hit, 0);
        check("d7_miss_way", bus.miss_way, 0);
        step();
        refill_line(32'h500);
        miss_fill(T6, 32'h600);

        // flush collides with a request: request refused, all tags gone afterwards
        bus.flush     = 1'b1;
        bus.req_valid = 1'b1;
        bus.req_tag   = T5;
        @(negedge clk);
        check("d8_ready_during_flush", bus.req_ready, 0);
        step();
        bus.flush     = 1'b0;
        bus.req_valid = 1'b0;
        @(negedge clk);
        check("d8_no_rsp", bus.rsp_valid, 0);
        step();
        issue(1'b0, T5, 4'd0, '0, '0);
        @(negedge clk);
        check("d9_t5_miss", bus.rsp_hit, 0);
        step();
        refill_line(32'h700);
        issue(1'b0, T6, 4'd0, '0, '0);
        @(negedge clk);
        check("d9_t6_miss", bus.rsp_hit, 0);
        step();
        refill_line(32'h800);

        // random traffic over a small tag pool
        beat = 0;
        for (int c = 0; c < 3000; c++) begin
            bus.req_write   = $urandom_range(0, 1);
            bus.req_tag     = pool[$urandom_range(0, 5)];
            bus.req_offset  = OW'($urandom_range(0, LINE - 1));
            bus.req_byte_en = BY'($urandom);
            bus.req_wdata   = $urandom;
            if (m_miss) begin
                bus.req_valid = ($urandom_range(0, 3) == 0);
                bus.flush     = ($urandom_range(0, 7) == 0);
                if ($urandom_range(0, 3) != 0) begin
                    bus.refill_valid  = 1'b1;
                    bus.refill_offset = OW'(beat);
                    bus.refill_data   = $urandom;
                    bus.refill_last   = (beat == LINE - 1);
                end else begin
                    bus.refill_valid = 1'b0;
                    bus.refill_last  = 1'b0;
                end
                step();
                if (bus.refill_valid) beat = bus.refill_last ? 0 : beat + 1;
            end else begin
                beat = 0;
                bus.req_valid     = ($urandom_range(0, 9) < 7);
                bus.flush         = ($urandom_range(0, 39) == 0);
                bus.refill_valid  = ($urandom_range(0, 7) == 0);
                bus.refill_offset = OW'($urandom_range(0, LINE - 1));
                bus.refill_data   = $urandom;
                bus.refill_last   = $urandom_range(0, 1);
                step();
            end
        end
        idle();
        repeat (3) step();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
